// File: rtl/bram_loader.sv
// Boot loader: parses a two-word header from a valid/ready word stream, writes the
// data and instruction images into their BRAMs, then releases the core.
module bram_loader #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [9:0]  d_w_addr,
  output logic [31:0] d_w_dat,
  output logic        d_w_enb,
  output logic [9:0]  i_w_addr,
  output logic [31:0] i_w_dat,
  output logic        i_w_enb,
  output logic        d_bram_init_done,
  output logic        pc_stall,
  output logic        i_r_enb,
  output logic        rd_enbl,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    IDLE, HDR_I, HDR_D, LOAD_D, LOAD_I, DRAIN, RUN, ERR
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [31:0]        n_i;
  logic [CNT_W-1:0]   n_d;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   idx_cnt;
  logic               accept;
  logic               last_d;
  logic               last_i;
  logic               hdr_bad;
  logic               run_next;

  // Next-state decode; header limits are checked on the full 32-bit words.
  always_comb begin
    state_next = state;
    accept     = s_valid && s_ready;
    idx_cnt    = CNT_W'(idx) + CNT_W'(1);
    last_d     = (idx_cnt == n_d);
    last_i     = (idx_cnt == CNT_W'(n_i));
    hdr_bad    = (n_i > 32'(DEPTH_WORDS)) || (s_data > 32'(DEPTH_WORDS));
    case (state)
      IDLE:    if (start) state_next = HDR_I;
      HDR_I:   if (accept) state_next = HDR_D;
      HDR_D: begin
        if (accept) begin
          if (hdr_bad)            state_next = ERR;
          else if (s_data != '0)  state_next = LOAD_D;
          else if (n_i != '0)     state_next = LOAD_I;
          else                    state_next = DRAIN;
        end
      end
      LOAD_D:  if (accept && last_d) state_next = (n_i != '0) ? LOAD_I : DRAIN;
      LOAD_I:  if (accept && last_i) state_next = DRAIN;
      DRAIN:   state_next = RUN;
      RUN:     if (start) state_next = HDR_I;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
    // Core-facing run outputs trail RUN entry by one edge so the core sees a drain cycle.
    run_next = (state == RUN) && (state_next == RUN);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Header capture and word index; index restarts at each load section.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_i <= '0;
      n_d <= '0;
      idx <= '0;
    end else begin
      if (state == HDR_I && accept) n_i <= s_data;
      if (state == HDR_D && accept) n_d <= CNT_W'(s_data);
      if (state_next != state && (state_next == LOAD_D || state_next == LOAD_I))
        idx <= '0;
      else if (accept && (state == LOAD_D || state == LOAD_I))
        idx <= idx + IDX_W'(1);
    end
  end

  // BRAM write ports: one registered strobe per accepted image word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_w_enb  <= 1'b0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
      i_w_enb  <= 1'b0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
    end else begin
      d_w_enb <= accept && (state == LOAD_D);
      i_w_enb <= accept && (state == LOAD_I);
      if (accept && state == LOAD_D) begin
        d_w_addr <= {idx, 2'b00};
        d_w_dat  <= s_data;
      end
      if (accept && state == LOAD_I) begin
        i_w_addr <= {idx, 2'b00};
        i_w_dat  <= s_data;
      end
    end
  end

  // Status outputs, registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ready          <= 1'b0;
      d_bram_init_done <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      s_ready  <= (state_next == HDR_I) || (state_next == HDR_D) ||
                  (state_next == LOAD_D) || (state_next == LOAD_I);
      error    <= (state_next == ERR);
      pc_stall <= !run_next;
      i_r_enb  <= run_next;
      rd_enbl  <= run_next;
      done     <= run_next;
      if (state_next == HDR_I)
        d_bram_init_done <= 1'b0;
      else if ((state == HDR_D || state == LOAD_D) &&
               (state_next == LOAD_I || state_next == DRAIN))
        d_bram_init_done <= 1'b1;
    end
  end

endmodule
